// File: rtl/nerv_pass_entry_if.sv
// Keypad-side and nerv-side signals of the pass-entry front-end.
interface nerv_pass_entry_if #(
  parameter int DIGITS = 4
);
  logic                  cs;
  logic                  key_valid;
  logic [3:0]            key_digit;
  logic                  key_enter;
  logic                  key_clear;
  logic                  prog_en;
  logic [4*DIGITS-1:0]   data_out;
  logic                  pass;
  logic                  wr;
  logic                  rd;
  logic                  fail;
  logic                  locked_out;
  logic [3:0]            tries_left;
  logic                  busy;

  // Keypad / host side drives the keys and watches the lock outputs.
  modport master (
    output cs, key_valid, key_digit, key_enter, key_clear, prog_en,
    input  data_out, pass, wr, rd, fail, locked_out, tries_left, busy
  );

  // The entry block itself.
  modport slave (
    input  cs, key_valid, key_digit, key_enter, key_clear, prog_en,
    output data_out, pass, wr, rd, fail, locked_out, tries_left, busy
  );
endinterface

// File: rtl/nerv_pass_entry.sv
// Keypad front-end for the nerv lock: digit collection, password compare,
// retry limit with timed lockout, and password reprogramming after a grant.
module nerv_pass_entry #(
  parameter int                  DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_PASS   = 16'h5423,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  GRANT_CYCLES   = 32,
  parameter int                  LOCKOUT_CYCLES = 1000
) (
  input logic              clk,
  input logic              reset,
  nerv_pass_entry_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int GW = $clog2(GRANT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_GRANT, S_DENY, S_LOCKOUT, S_PROGRAM
  } state_t;

  // Registered single-bit outputs, computed one cycle ahead from next state.
  typedef struct packed {
    logic pass;
    logic wr;
    logic rd;
    logic fail;
    logic locked_out;
    logic busy;
  } flags_t;

  state_t          state, state_d;
  logic [W-1:0]    code_buf;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    password;
  logic [W-1:0]    dout_q;
  logic [3:0]      tries_q;
  logic [GW-1:0]   gcnt, gcnt_d;
  logic [LW-1:0]   lcnt, lcnt_d;
  logic            prog_seen;
  flags_t          flg_d, flg_q;

  logic keys_on, clr_hit, do_enter, do_digit, full, match;

  // Key strobe decode: clear beats enter beats digit; keys only count when
  // selected and in a state that collects digits.
  always_comb begin
    keys_on  = bus.cs && (state == S_IDLE || state == S_ENTRY || state == S_PROGRAM);
    clr_hit  = keys_on && bus.key_clear;
    do_enter = keys_on && !bus.key_clear && bus.key_enter;
    full     = (cnt == CW'(DIGITS));
    do_digit = keys_on && !bus.key_clear && !bus.key_enter && bus.key_valid &&
               (bus.key_digit <= 4'd9) && !full;
    match    = full && (code_buf == password);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (do_enter) state_d = S_CHECK;
                 else if (do_digit) state_d = S_ENTRY;
      S_ENTRY:   if (do_enter) state_d = S_CHECK;
      S_CHECK:   state_d = match ? S_GRANT : S_DENY;
      S_GRANT:   if (gcnt == GW'(GRANT_CYCLES))
                   state_d = (prog_seen || bus.prog_en) ? S_PROGRAM : S_IDLE;
      S_DENY:    state_d = (tries_q <= 4'd1) ? S_LOCKOUT : S_IDLE;
      S_LOCKOUT: if (lcnt == LW'(LOCKOUT_CYCLES)) state_d = S_IDLE;
      S_PROGRAM: if (do_enter) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / counter logic: the grant and lockout counters hold the 1-based
  // index of the current cycle in that state, so strobes fall out directly.
  always_comb begin
    gcnt_d = '0;
    lcnt_d = '0;
    if (state_d == S_GRANT)
      gcnt_d = (state == S_GRANT) ? gcnt + GW'(1) : GW'(1);
    if (state_d == S_LOCKOUT)
      lcnt_d = (state == S_LOCKOUT) ? lcnt + LW'(1) : LW'(1);
    flg_d            = '0;
    flg_d.pass       = (state_d == S_GRANT);
    flg_d.wr         = (state_d == S_GRANT) && (gcnt_d == GW'(1));
    flg_d.rd         = (state_d == S_GRANT) && (gcnt_d == GW'(GRANT_CYCLES));
    flg_d.fail       = (state_d == S_DENY);
    flg_d.locked_out = (state_d == S_LOCKOUT);
    flg_d.busy       = (state_d == S_CHECK) || (state_d == S_GRANT) ||
                       (state_d == S_DENY)  || (state_d == S_LOCKOUT);
  end

  // Output flag and cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      flg_q <= '0;
      gcnt  <= '0;
      lcnt  <= '0;
    end else begin
      flg_q <= flg_d;
      gcnt  <= gcnt_d;
      lcnt  <= lcnt_d;
    end
  end

  // Digit buffer: shift in accepted digits, empty on clear, after a compare,
  // and when a programming entry is closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_buf <= '0;
      cnt      <= '0;
    end else if (state == S_CHECK) begin
      code_buf <= '0;
      cnt      <= '0;
    end else if (clr_hit && state != S_IDLE) begin
      code_buf <= '0;
      cnt      <= '0;
    end else if (do_enter && state == S_PROGRAM) begin
      code_buf <= '0;
      cnt      <= '0;
    end else if (do_digit) begin
      code_buf <= {code_buf[W-5:0], bus.key_digit};
      cnt      <= cnt + CW'(1);
    end
  end

  // Password store and the code presented to the lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      password <= DEFAULT_PASS;
      dout_q   <= '0;
    end else if (do_enter) begin
      if (state == S_PROGRAM) begin
        if (full) password <= code_buf;
      end else begin
        dout_q <= code_buf;
      end
    end
  end

  // Retry budget: refilled on a match or when the lockout expires.
  always_ff @(posedge clk) begin
    if (reset)
      tries_q <= 4'(MAX_TRIES);
    else if (state == S_CHECK && match)
      tries_q <= 4'(MAX_TRIES);
    else if (state == S_DENY)
      tries_q <= tries_q - 4'd1;
    else if (state == S_LOCKOUT && state_d == S_IDLE)
      tries_q <= 4'(MAX_TRIES);
  end

  // Remember a program request seen on any grant cycle before the last.
  always_ff @(posedge clk) begin
    if (reset)
      prog_seen <= 1'b0;
    else
      prog_seen <= (state == S_GRANT) && (state_d == S_GRANT) &&
                   (prog_seen || bus.prog_en);
  end

  assign bus.data_out   = dout_q;
  assign bus.pass       = flg_q.pass;
  assign bus.wr         = flg_q.wr;
  assign bus.rd         = flg_q.rd;
  assign bus.fail       = flg_q.fail;
  assign bus.locked_out = flg_q.locked_out;
  assign bus.busy       = flg_q.busy;
  assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_nerv_pass_entry.sv
// Directed plus randomized bench for nerv_pass_entry against a code-level model.
module tb_nerv_pass_entry;
  localparam int G  = 32;
  localparam int L  = 1000;
  localparam int MT = 3;

  logic clk = 1'b0;
  logic reset;
  nerv_pass_entry_if #(.DIGITS(4)) bus();

  nerv_pass_entry #(
    .DIGITS(4), .DEFAULT_PASS(16'h5423), .MAX_TRIES(MT),
    .GRANT_CYCLES(G), .LOCKOUT_CYCLES(L)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] m_pass   = 16'h5423;
  int          m_tries  = MT;
  logic [3:0]  seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: first four digits 0..9 form the code, anything else is dropped.
  function automatic void model_buf(output logic [15:0] b, output int c);
    b = 16'h0;
    c = 0;
    foreach (seq[i])
      if (seq[i] <= 4'd9 && c < 4) begin
        b = b * 16 + 16'(seq[i]);
        c++;
      end
  endfunction

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic press_seq();
    foreach (seq[i]) press(seq[i]);
  endtask

  // Enter whatever seq describes and follow the grant or deny/lockout timeline.
  task automatic submit(input bit with_valid, input logic [3:0] vd, input bit prog);
    logic [15:0] b;
    int          c;
    bit          match;
    model_buf(b, c);
    match = (c == 4) && (b == m_pass);
    @(negedge clk);
    bus.key_enter = 1'b1;
    bus.key_valid = with_valid;
    bus.key_digit = vd;
    @(negedge clk);
    bus.key_enter = 1'b0;
    bus.key_valid = 1'b0;
    chk("check_busy", bus.busy, 1);
    chk("data_out", bus.data_out, b);
    chk("check_pass", bus.pass, 0);
    @(negedge clk);
    if (match) begin
      m_tries = MT;
      bus.prog_en = prog;
      chk("grant_pass", bus.pass, 1);
      chk("grant_wr", bus.wr, 1);
      chk("grant_fail", bus.fail, 0);
      chk("grant_tries", bus.tries_left, m_tries);
      for (int j = 2; j <= G; j++) begin
        @(negedge clk);
        chk("grant_hold", bus.pass, 1);
        chk("grant_wr_once", bus.wr, 0);
        chk("grant_rd", bus.rd, (j == G) ? 1 : 0);
      end
      bus.prog_en = 1'b0;
      @(negedge clk);
      chk("grant_end_pass", bus.pass, 0);
      chk("grant_end_rd", bus.rd, 0);
      chk("grant_end_busy", bus.busy, 0);
    end else begin
      chk("deny_fail", bus.fail, 1);
      chk("deny_pass", bus.pass, 0);
      chk("deny_wr", bus.wr, 0);
      chk("deny_busy", bus.busy, 1);
      m_tries--;
      @(negedge clk);
      chk("deny_tries", bus.tries_left, m_tries);
      chk("deny_fail_once", bus.fail, 0);
      if (m_tries == 0) begin
        chk("lock_start", bus.locked_out, 1);
        for (int j = 2; j <= L; j++) begin
          @(negedge clk);
          bus.key_valid = (j % 100 == 0);
          bus.key_digit = 4'd5;
          if (j == L) chk("lock_last", bus.locked_out, 1);
        end
        bus.key_valid = 1'b0;
        @(negedge clk);
        chk("lock_end", bus.locked_out, 0);
        chk("lock_end_busy", bus.busy, 0);
        chk("lock_end_tries", bus.tries_left, MT);
        m_tries = MT;
      end else begin
        chk("deny_no_lock", bus.locked_out, 0);
        chk("deny_end_busy", bus.busy, 0);
      end
    end
  endtask

  // Entry while in PROGRAM: only a full code replaces the password.
  task automatic program_entry();
    logic [15:0] b;
    int          c;
    model_buf(b, c);
    press_seq();
    @(negedge clk);
    bus.key_enter = 1'b1;
    @(negedge clk);
    bus.key_enter = 1'b0;
    chk("prog_busy", bus.busy, 0);
    chk("prog_pass", bus.pass, 0);
    chk("prog_fail", bus.fail, 0);
    if (c == 4) m_pass = b;
  endtask

  task automatic attempt(input logic [15:0] code);
    seq = {code[15:12], code[11:8], code[7:4], code[3:0]};
    press_seq();
    submit(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int n;
    bus.cs = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.prog_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pass", bus.pass, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_locked", bus.locked_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tries", bus.tries_left, MT);
    chk("rst_data_out", bus.data_out, 0);
    reset = 1'b0;

    // Correct default code, then three wrong codes into lockout.
    attempt(16'h5423);
    repeat (3) attempt(16'h1111);
    attempt(16'h5423);

    // Short entry, then an overlong one with the extra digit dropped.
    seq = {4'd5, 4'd4}; press_seq(); submit(1'b0, 4'd0, 1'b0);
    seq = {4'd5, 4'd4, 4'd2, 4'd3, 4'd9}; press_seq(); submit(1'b0, 4'd0, 1'b0);

    // Clear wins over a same-cycle digit and empties the buffer.
    seq = {4'd5, 4'd4}; press_seq();
    @(negedge clk);
    bus.key_clear = 1'b1; bus.key_valid = 1'b1; bus.key_digit = 4'd2;
    @(negedge clk);
    bus.key_clear = 1'b0; bus.key_valid = 1'b0;
    attempt(16'h5423);

    // Enter wins over a same-cycle digit.
    seq = {4'd5, 4'd4, 4'd2, 4'd3}; press_seq(); submit(1'b1, 4'd7, 1'b0);

    // Deselecting mid-entry holds the partial code and ignores keys.
    seq = {4'd5, 4'd4, 4'd2, 4'd3};
    press(4'd5); press(4'd4);
    bus.cs = 1'b0;
    press(4'd9);
    @(negedge clk); bus.key_clear = 1'b1;
    @(negedge clk); bus.key_clear = 1'b0;
    bus.cs = 1'b1;
    press(4'd2); press(4'd3);
    submit(1'b0, 4'd0, 1'b0);

    // Reprogramming: a short entry is discarded, a full one is stored.
    seq = {4'd5, 4'd4, 4'd2, 4'd3}; press_seq(); submit(1'b0, 4'd0, 1'b1);
    seq = {4'd7, 4'd7}; program_entry();
    attempt(16'h5423);
    seq = {4'd5, 4'd4, 4'd2, 4'd3}; press_seq(); submit(1'b0, 4'd0, 1'b1);
    seq = {4'd1, 4'd2, 4'd3, 4'd4}; program_entry();
    attempt(16'h5423);
    attempt(16'h1234);

    // Reset in the middle of a grant restores the default password.
    seq = {4'd1, 4'd2, 4'd3, 4'd4}; press_seq();
    @(negedge clk); bus.key_enter = 1'b1;
    @(negedge clk); bus.key_enter = 1'b0;
    repeat (5) @(negedge clk);
    chk("midgrant_pass", bus.pass, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_grant_pass", bus.pass, 0);
    chk("rst_grant_busy", bus.busy, 0);
    chk("rst_grant_tries", bus.tries_left, MT);
    chk("rst_grant_dout", bus.data_out, 0);
    m_pass = 16'h5423;
    m_tries = MT;
    attempt(16'h5423);

    // Random entries: mostly noise, sometimes the real code, sometimes padded.
    for (int t = 0; t < 12; t++) begin
      seq = {};
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 3; i >= 0; i--) seq.push_back(m_pass[i*4 +: 4]);
        if ($urandom_range(0, 1) == 1) seq.push_back(4'($urandom_range(0, 15)));
      end else begin
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) seq.push_back(4'($urandom_range(0, 11)));
      end
      press_seq();
      submit(1'b0, 4'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
